// File: rtl/sort9_sched.sv
// Round-robin scheduler sharing one pipelined 9-sample sorter among NUM_REQ requesters.
// Optional SORT9_SCHED_STATS_EN adds saturating jobs_done / stall_cycles counters.
module sort9_sched #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SORT_LAT = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ),
    localparam int unsigned CNT_W   = $clog2(SORT_LAT + 1),
    localparam int unsigned VEC_W   = 9 * DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*VEC_W-1:0] req_data,
    output logic [VEC_W-1:0]         sort_in,
    output logic                     sort_en,
    input  logic [VEC_W-1:0]         sort_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [VEC_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]        rsp_median,
`ifdef SORT9_SCHED_STATS_EN
    output logic [15:0]              jobs_done,
    output logic [15:0]              stall_cycles,
`endif
    output logic [CNT_W-1:0]         inflight
);

    logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]                grant_id;
    logic [ID_W:0]                  cand;
    logic                           found;
    logic                           any_req;
    logic                           head_v;
    logic                           stall;
    logic                           adv;
    logic                           accept;
    logic [SORT_LAT-1:0]            tag_v_q, tag_v_d;
    logic [SORT_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
    logic [CNT_W-1:0]               inflight_q, inflight_d;

    assign any_req = |req_valid;
    assign head_v  = tag_v_q[SORT_LAT-1];
    // Only a valid head that cannot retire freezes the pipe; bubbles always flow.
    assign stall   = head_v & ~rsp_ready;
    assign adv     = ~stall;
    assign accept  = adv & any_req;
    assign sort_en = adv;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_id = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found    = 1'b1;
                grant_id = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        sort_in = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (any_req && (grant_id == ID_W'(r))) begin
                sort_in = req_data[r*VEC_W +: VEC_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // Tag pipeline mirrors the sorter stages so the ID emerges alongside its data.
    always_comb begin
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        if (adv) begin
            tag_v_d[0]  = any_req;
            tag_id_d[0] = grant_id;
            for (int unsigned i = 1; i < SORT_LAT; i++) begin
                tag_v_d[i]  = tag_v_q[i-1];
                tag_id_d[i] = tag_id_q[i-1];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        unique case ({accept, adv & head_v})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            inflight_q <= inflight_d;
        end
    end

    assign rsp_valid  = head_v;
    assign rsp_id     = tag_id_q[SORT_LAT-1];
    assign rsp_data   = sort_out;
    assign rsp_median = sort_out[4*DATA_W +: DATA_W];
    assign inflight   = inflight_q;

`ifdef SORT9_SCHED_STATS_EN
    logic [15:0] jobs_done_q, jobs_done_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        jobs_done_d    = jobs_done_q;
        stall_cycles_d = stall_cycles_q;
        if (head_v && rsp_ready && (jobs_done_q != 16'hFFFF)) begin
            jobs_done_d = jobs_done_q + 16'd1;
        end
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jobs_done_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            jobs_done_q    <= jobs_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign jobs_done    = jobs_done_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/sort9_sched.md
Name: sort9_sched

Overview:
- Arbiter/sequencer that shares one pipelined 9-sample, 8-bit sorting network among NUM_REQ requesters.
- Each cycle: round-robin pick of one pending 9-sample job, drive it into the sorter, carry the requester ID alongside the sorter latency.
- Returns the sorted vector plus median to the requester through a valid/ready response port.
- Owns the sorter's clock-enable (the H gating input) and stalls the whole pipeline on response backpressure.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- DATA_W, 8, sample width.
- SORT_LAT, 4, sorter latency in enabled clocks, input to output; must equal the sorter's stage count.

Ports:
- clk  in  1  system clock.
- reset  in  1  async active-high; also wired to the sorter reset.
- req_valid  in  NUM_REQ  per-requester job pending.
- req_ready  out  NUM_REQ  one-hot grant; job accepted when valid&ready at posedge.
- req_data  in  NUM_REQ*9*DATA_W  requester r occupies bits [r*9*DATA_W +: 9*DATA_W]; sample k at [k*DATA_W +: DATA_W].
- sort_in  out  9*DATA_W  to sorter inputs, same sample packing.
- sort_en  out  1  sorter clock enable (H).
- sort_out  in  9*DATA_W  from sorter; sample 8 largest, sample 0 smallest.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  $clog2(NUM_REQ)  originating requester.
- rsp_data  out  9*DATA_W  sort_out passthrough.
- rsp_median  out  DATA_W  sample 4 of sort_out.
- inflight  out  $clog2(SORT_LAT+1)  valid jobs in the pipeline.

Behaviour:
- Interface: reset is reset, asynchronous, active-high; clock is clk.
- Reset values: all zero.
  - rr_ptr=0, tag pipeline valid bits=0, inflight=0, rsp_valid=0, rsp_id=0.
  - sort_en=1 (pipeline free-runs while empty).
- stall = tag[SORT_LAT-1].valid & ~rsp_ready; adv = ~stall; sort_en = adv (combinational).
- Arbitration (combinational):
  - g = first r with req_valid[r], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - any = |req_valid.
  - req_ready = adv&any ? onehot(g) : 0.
  - sort_in = req_data slice g; when ~any, sort_in = 0.
- Tag pipeline: SORT_LAT entries of {v, id}.
  - On adv: tag[0] <= {any, g}; tag[i] <= tag[i-1].
  - On stall: all entries hold; sorter holds because sort_en=0.
- rr_ptr: on adv&any, rr_ptr <= (g+1) mod NUM_REQ; otherwise holds.
- Response:
  - rsp_valid = tag[SORT_LAT-1].v; rsp_id = tag[SORT_LAT-1].id.
  - rsp_data = sort_out; rsp_median = sort_out[4*DATA_W +: DATA_W].
  - Result completes on rsp_valid&rsp_ready.
- Latency: job accepted at edge N appears with rsp_valid after SORT_LAT-1 further advancing edges (N+SORT_LAT-1 with no stalls).
- Throughput: 1 job/cycle sustained.
- inflight:
  - Registered count of set v bits.
  - +1 on adv&any; -1 on adv&tag[SORT_LAT-1].v; both at once: unchanged.
- Boundaries:
  - No requests: bubbles enter (v=0); pipeline keeps advancing.
  - rsp_ready low with an invalid head: no stall.
  - A requester dropping req_valid without a grant is legal; no job is created.
- Reset mid-operation: all in-flight jobs are discarded and no response is issued; sorter contents are cleared by the shared reset.

Optional Feature:
- SORT9_SCHED_STATS_EN defined: adds outputs jobs_done[15:0] and stall_cycles[15:0].
  - jobs_done increments on rsp_valid&rsp_ready.
  - stall_cycles increments on each stall cycle.
  - Both saturate at 16'hFFFF, reset to 0.
- Undefined: ports absent, no counter logic.

Test Plan:
- Single job: req 2 valid with samples {9,1,8,2,7,3,6,4,5}, rsp_ready=1.
  - req_ready=4'b0100 for one cycle.
  - After 3 more edges: rsp_valid=1, rsp_id=2, rsp_median=5, rsp_data sample8=9, sample0=1.
- Round-robin: all 4 requesters held valid, rsp_ready=1.
  - Grants 0,1,2,3,0,… one per cycle.
  - Responses in the same ID order, back-to-back; inflight saturates at 4.
- Backpressure: 3 jobs in flight, rsp_ready=0 for 5 cycles.
  - rsp_valid and rsp_id stable, sort_en=0, req_ready=0 throughout.
  - Release: the remaining jobs drain on consecutive cycles, no loss or duplication.
- Bubbles: jobs accepted at cycles 0 and 2 only → rsp_valid high at cycles 3 and 5, low at 4.
- Reset mid-run: assert reset with inflight=3.
  - All outputs return to reset values immediately; no rsp_valid after release until new jobs complete.
- Stats (SORT9_SCHED_STATS_EN): 10 jobs completed and 7 stall cycles → jobs_done=10, stall_cycles=7; preload near max and confirm hold at 16'hFFFF.
